// File: rtl/sha256_host_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha256_host_pkg
// Description : Shared types, constants and helpers for the SHA-256 host
//               controller slice.
// Revision    : 1.0 - initial release
// ============================================================================
package sha256_host_pkg;

    // Controller states, in the order a run visits them.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RD_ADDR = 3'd4,
        ST_RD_DATA = 3'd5,
        ST_FIN     = 3'd6
    } host_state_t;

    // The digest is always eight 32-bit words (H0..H7).
    localparam int DIGEST_WORDS = 8;
    localparam int DIGEST_IDX_W = 3;

    // Rotate a message word left by one bit to derive the next word.
    function automatic logic [31:0] rotl1(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_host_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sha256_host_ctrl_if
// Description : SRAM port, coprocessor start/done and digest stream signals
//               of the SHA-256 host controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface sha256_host_ctrl_if;

    // Shared SRAM port owned by the host
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    // Coprocessor control
    logic        sha_start;
    logic [15:0] sha_message_addr;
    logic [15:0] sha_output_addr;
    logic        sha_done;

    // Digest stream
    logic        hash_valid;
    logic [31:0] hash_data;
    logic [2:0]  hash_idx;
    logic        hash_ready;

    // Host controller side
    modport master (
        output mem_we, mem_addr, mem_write_data,
        input  mem_read_data,
        output sha_start, sha_message_addr, sha_output_addr,
        input  sha_done,
        output hash_valid, hash_data, hash_idx,
        input  hash_ready
    );

    // Memory / coprocessor / sink side
    modport slave (
        input  mem_we, mem_addr, mem_write_data,
        output mem_read_data,
        input  sha_start, sha_message_addr, sha_output_addr,
        output sha_done,
        input  hash_valid, hash_data, hash_idx,
        output hash_ready
    );

endinterface
`default_nettype wire

// File: rtl/sha256_msg_gen.sv
`default_nettype none
// ============================================================================
// Module      : sha256_msg_gen
// Description : Seed-derived message word generator. Loads a seed, advances
//               by rotate-left-by-1 and counts words, flagging the last one.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_msg_gen
    import sha256_host_pkg::*;
#(
    parameter int NUM_OF_WORDS = 40,
    parameter int CNT_W        = 6
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             load,
    input  wire logic             advance,
    input  wire logic [31:0]      seed,
    output logic      [31:0]      word,
    output logic      [CNT_W-1:0] count,
    output logic                  last
);

    logic [31:0]      word_q, word_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next word/count: load wins over advance.
    always_comb begin
        word_d  = word_q;
        count_d = count_q;
        if (load) begin
            word_d  = seed;
            count_d = '0;
        end else if (advance) begin
            word_d  = rotl1(word_q);
            count_d = count_q + 1'b1;
        end
    end

    // Word and counter registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            word_q  <= '0;
            count_q <= '0;
        end else begin
            word_q  <= word_d;
            count_q <= count_d;
        end
    end

    assign word  = word_q;
    assign count = count_q;
    assign last  = (count_q == CNT_W'(NUM_OF_WORDS - 1));

endmodule
`default_nettype wire

// File: rtl/sha256_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sha256_host_ctrl
// Description : Host-side driver for the SHA-256 coprocessor. Writes a
//               seed-derived message into shared SRAM, starts the
//               coprocessor, waits for done, then reads back and streams the
//               8-word digest together with the coprocessor cycle count.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_host_ctrl
    import sha256_host_pkg::*;
#(
    parameter int          NUM_OF_WORDS = 40,
    parameter logic [15:0] MSG_ADDR     = 16'd0,
    parameter logic [15:0] OUT_ADDR     = 16'd1000
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    input  wire logic        go,
    input  wire logic [31:0] seed,
    output logic             busy,
    output logic [31:0]      cycle_count,
    output logic             finished,
    sha256_host_ctrl_if.master bus
);

    localparam int CNT_W = (NUM_OF_WORDS > 1) ? $clog2(NUM_OF_WORDS) : 1;

    host_state_t             state_q, state_d;
    logic                    start_cnt_q, start_cnt_d;
    logic [DIGEST_IDX_W-1:0] n_q, n_d;
    logic                    captured_q, captured_d;
    logic [31:0]             hash_data_q, hash_data_d;
    logic [31:0]             cycle_count_q, cycle_count_d;

    logic                    gen_load;
    logic                    gen_advance;
    logic [31:0]             gen_word;
    logic [CNT_W-1:0]        gen_count;
    logic                    gen_last;

    sha256_msg_gen #(
        .NUM_OF_WORDS (NUM_OF_WORDS),
        .CNT_W        (CNT_W)
    ) u_msg_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (gen_load),
        .advance (gen_advance),
        .seed    (seed),
        .word    (gen_word),
        .count   (gen_count),
        .last    (gen_last)
    );

    // Next-state, read capture and cycle-count logic.
    always_comb begin
        state_d       = state_q;
        start_cnt_d   = start_cnt_q;
        n_d           = n_q;
        captured_d    = captured_q;
        hash_data_d   = hash_data_q;
        cycle_count_d = cycle_count_q;
        gen_load      = 1'b0;
        gen_advance   = 1'b0;

        // Coprocessor time is counted in START and WAIT, including the
        // cycle on which done is sampled; saturates rather than wrapping.
        if ((state_q == ST_START || state_q == ST_WAIT) && (cycle_count_q != 32'hFFFF_FFFF)) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    gen_load      = 1'b1;
                    cycle_count_d = '0;
                    n_d           = '0;
                    state_d       = ST_WRITE;
                end
            end
            ST_WRITE: begin
                gen_advance = 1'b1;
                if (gen_last) begin
                    start_cnt_d = 1'b0;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                start_cnt_d = 1'b1;
                if (start_cnt_q) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.sha_done) begin
                    n_d     = '0;
                    state_d = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                captured_d = 1'b0;
                state_d    = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                // First cycle grabs the SRAM word; afterwards it is offered
                // and held until the sink takes it.
                if (!captured_q) begin
                    hash_data_d = bus.mem_read_data;
                    captured_d  = 1'b1;
                end else if (bus.hash_ready) begin
                    if (n_q == DIGEST_IDX_W'(DIGEST_WORDS - 1)) begin
                        state_d = ST_FIN;
                    end else begin
                        n_d     = n_q + 1'b1;
                        state_d = ST_RD_ADDR;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            start_cnt_q   <= 1'b0;
            n_q           <= '0;
            captured_q    <= 1'b0;
            hash_data_q   <= '0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            start_cnt_q   <= start_cnt_d;
            n_q           <= n_d;
            captured_q    <= captured_d;
            hash_data_q   <= hash_data_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    // Outputs decode only from registered state, so no input reaches an
    // output combinationally.
    always_comb begin
        bus.mem_we         = (state_q == ST_WRITE);
        bus.mem_write_data = (state_q == ST_WRITE) ? gen_word : 32'd0;
        bus.mem_addr       = 16'd0;
        if (state_q == ST_WRITE) begin
            bus.mem_addr = MSG_ADDR + 16'(gen_count);
        end else if (state_q == ST_RD_ADDR) begin
            bus.mem_addr = OUT_ADDR + 16'(n_q);
        end
    end

    assign bus.sha_start        = (state_q == ST_START);
    assign bus.sha_message_addr = MSG_ADDR;
    assign bus.sha_output_addr  = OUT_ADDR;
    assign bus.hash_valid       = (state_q == ST_RD_DATA) && captured_q;
    assign bus.hash_data        = hash_data_q;
    assign bus.hash_idx         = n_q;

    assign busy        = (state_q != ST_IDLE);
    assign finished    = (state_q == ST_FIN);
    assign cycle_count = cycle_count_q;

endmodule
`default_nettype wire

// File: tb/tb_sha256_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256_host_ctrl
// Description : Directed self-checking bench for sha256_host_ctrl with a
//               behavioural SRAM and a scripted coprocessor done signal.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_host_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        go;
    logic [31:0] seed;
    logic        busy;
    logic [31:0] cycle_count;
    logic        finished;

    sha256_host_ctrl_if bus();

    sha256_host_ctrl #(
        .NUM_OF_WORDS (40),
        .MSG_ADDR     (16'd0),
        .OUT_ADDR     (16'd1000)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .go          (go),
        .seed        (seed),
        .busy        (busy),
        .cycle_count (cycle_count),
        .finished    (finished),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM, bench preload port and activity counters.
    logic [31:0] sram [0:2047];
    logic        pl_en;
    logic [10:0] pl_addr;
    logic [31:0] pl_data;
    logic        clr;
    int          wr_count, start_cycles, rd_hits, fin_count;

    always @(posedge clk) begin
        if (pl_en) sram[pl_addr] <= pl_data;
        else if (bus.mem_we) sram[bus.mem_addr[10:0]] <= bus.mem_write_data;
        bus.mem_read_data <= sram[bus.mem_addr[10:0]];
        if (clr) begin
            wr_count <= 0; start_cycles <= 0; rd_hits <= 0; fin_count <= 0;
        end else begin
            if (bus.mem_we) wr_count <= wr_count + 1;
            if (bus.sha_start) start_cycles <= start_cycles + 1;
            if (!bus.mem_we && bus.mem_addr >= 16'd1000 && bus.mem_addr <= 16'd1007) rd_hits <= rd_hits + 1;
            if (finished) fin_count <= fin_count + 1;
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_busy"},     32'(busy), 32'd0);
        chk({pfx, "_we"},       32'(bus.mem_we), 32'd0);
        chk({pfx, "_addr"},     32'(bus.mem_addr), 32'd0);
        chk({pfx, "_wdata"},    bus.mem_write_data, 32'd0);
        chk({pfx, "_start"},    32'(bus.sha_start), 32'd0);
        chk({pfx, "_valid"},    32'(bus.hash_valid), 32'd0);
        chk({pfx, "_hdata"},    bus.hash_data, 32'd0);
        chk({pfx, "_hidx"},     32'(bus.hash_idx), 32'd0);
        chk({pfx, "_ccount"},   cycle_count, 32'd0);
        chk({pfx, "_finished"}, 32'(finished), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset_n = 1'b0; go = 1'b0; seed = '0;
        bus.sha_done = 1'b0; bus.hash_ready = 1'b0;
        clr = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;

        // Preload the digest area with 0..7 while reset is held.
        for (int i = 0; i < 8; i++) begin
            pl_en = 1'b1; pl_addr = 11'(1000 + i); pl_data = 32'(i);
            tick();
        end
        pl_en = 1'b0; clr = 1'b0;

        chk_reset_outputs("rst");
        chk("msg_addr", 32'(bus.sha_message_addr), 32'd0);
        chk("out_addr", 32'(bus.sha_output_addr), 32'd1000);
        reset_n = 1'b1;
        tick();

        // ---------------- Run 1: seed 01234675, done after 100 cycles
        seed = 32'h0123_4675; go = 1'b1;
        tick();
        go = 1'b0;
        chk("w0_we",   32'(bus.mem_we), 32'd1);
        chk("w0_addr", 32'(bus.mem_addr), 32'd0);
        chk("w0_data", bus.mem_write_data, 32'h0123_4675);
        chk("w0_busy", 32'(busy), 32'd1);
        cyc = 0;
        while (!bus.sha_start && cyc < 200) begin tick(); cyc++; end
        chk("start_latency", 32'(cyc), 32'd40);
        chk("wr_count", 32'(wr_count), 32'd40);
        chk("sram0",  sram[0],  32'h0123_4675);
        chk("sram1",  sram[1],  32'h0246_8CEA);
        chk("sram39", sram[39], 32'h91A3_3A80);

        // Go pulse while in WAIT must be dropped.
        repeat (50) tick();
        go = 1'b1;
        tick();
        go = 1'b0;
        repeat (49) tick();
        bus.sha_done = 1'b1;
        chk("start_cycles", 32'(start_cycles), 32'd2);

        for (int i = 0; i < 8; i++) begin
            cyc = 0;
            while (!bus.hash_valid && cyc < 20) begin tick(); cyc++; end
            bus.sha_done = 1'b0;
            chk("valid_seen", 32'(bus.hash_valid), 32'd1);
            chk("hash_data",  bus.hash_data, 32'(i));
            chk("hash_idx",   32'(bus.hash_idx), 32'(i));
            if (i == 3) begin
                repeat (5) tick();
                chk("stall_valid", 32'(bus.hash_valid), 32'd1);
                chk("stall_data",  bus.hash_data, 32'd3);
                chk("stall_idx",   32'(bus.hash_idx), 32'd3);
            end
            bus.hash_ready = 1'b1;
            tick();
            bus.hash_ready = 1'b0;
        end
        chk("fin_pulse",   32'(finished), 32'd1);
        chk("cycle_count", cycle_count, 32'd101);
        tick();
        chk("fin_low",  32'(finished), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        repeat (60) tick();
        chk("one_run_busy",  32'(busy), 32'd0);
        chk("one_run_wr",    32'(wr_count), 32'd40);
        chk("fin_count",     32'(fin_count), 32'd1);
        chk("rd_hits",       32'(rd_hits), 32'd8);
        chk("start_total",   32'(start_cycles), 32'd2);
        chk("ccount_hold",   cycle_count, 32'd101);

        // ---------------- Run 2: reset during WRITE at m=10
        clr = 1'b1;
        tick();
        clr = 1'b0;
        seed = 32'h8000_0001; go = 1'b1;
        tick();
        go = 1'b0;
        repeat (10) tick();
        chk("mid_addr", 32'(bus.mem_addr), 32'd10);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk_reset_outputs("midrst");

        // ---------------- Run 3: fresh go, done already high, ready tied high
        seed = 32'hA5A5_A5A5; go = 1'b1;
        bus.sha_done = 1'b1; bus.hash_ready = 1'b1;
        tick();
        go = 1'b0;
        chk("r3_w0_addr", 32'(bus.mem_addr), 32'd0);
        chk("r3_w0_data", bus.mem_write_data, 32'hA5A5_A5A5);
        for (int i = 0; i < 8; i++) begin
            cyc = 0;
            while (!bus.hash_valid && cyc < 200) begin tick(); cyc++; end
            bus.sha_done = 1'b0;
            chk("r3_valid", 32'(bus.hash_valid), 32'd1);
            chk("r3_data",  bus.hash_data, 32'(i));
            tick();
        end
        chk("r3_fin",    32'(finished), 32'd1);
        chk("r3_ccount", cycle_count, 32'd3);
        chk("r3_sram0",  sram[0],  32'hA5A5_A5A5);
        chk("r3_sram1",  sram[1],  32'h4B4B_4B4B);
        chk("r3_sram39", sram[39], 32'hD2D2_D2D2);
        chk("r3_wr",     32'(wr_count), 32'd51);
        chk("r3_start",  32'(start_cycles), 32'd2);
        chk("r3_rd",     32'(rd_hits), 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
